gp22_seq_ctrl: RTL and testbench
================================

# gp22_seq_ctrl

Command sequencer for the GP22 TDC SPI engine. After reset it issues the TDC power-on-reset opcode and writes configuration registers 0–6. It then loops Init → wait for the TDC interrupt → read result register 0 → read status, presenting each measurement with a one-cycle valid strobe. It sits between the ranging datapath and the SPI engine, and is the only master of the engine's command port.

## Interface
Parameters:
- CFG_REG0 … CFG_REG6, 32'h0000_0000 each: values written to GP22 config registers 0–6 (opcodes 8'h80 … 8'h86).
- RESET_WAIT, 16'd256: idle cycles after reset before the first command. Must be ≥ 200, which covers an engine transfer left running across reset.
- TIMEOUT_CYC, 16'd4000: maximum cycles in WAIT_INT before the measurement is aborted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- start_en  in  1  level; enables the measurement loop.
- tdc_intn  in  1  GP22 INTN pin, asynchronous, active-low. Two-flop synchronised internally.
- CMD_TDCwr  out  1  write request (opcode + 32-bit data) to the engine.
- CMD_TDCrd  out  1  read request (opcode + 32-bit read) to the engine.
- CMD_TDC1byte  out  1  opcode-only request to the engine.
- TDC_CMD  out  8  opcode for the current request.
- TDC_WRdata  out  32  write data for the current request.
- TDC_CMDack  in  1  engine accepted the request (1-cycle pulse).
- TDC_RDdata  in  32  engine read data. Valid when TDC_CMDdone is high.
- TDC_CMDdone  in  1  engine transfer complete (1-cycle pulse).
- cfg_done  out  1  level; high once all 7 config writes have completed.
- tdc_result  out  32  last result register 0 value.
- tdc_status  out  16  last status value, equal to TDC_RDdata[31:16] of the 8'hB4 read.
- result_valid  out  1  1-cycle pulse; tdc_result and tdc_status are updated.
- timeout_err  out  1  1-cycle pulse; INTN did not arrive within TIMEOUT_CYC.

## Operation
- States: RST_WAIT, POR, CFG_WR, IDLE, INIT, WAIT_INT, RD_RES, RD_STAT, OUT.
- RST_WAIT: count RESET_WAIT cycles, then go to POR. Ignore TDC_CMDack and TDC_CMDdone throughout this state.
- POR: issue 1byte 8'h50, then go to CFG_WR with idx = 0.
- CFG_WR: issue wr with TDC_CMD = 8'h80 + idx and TDC_WRdata = CFG_REG[idx].
  - On done with idx = 6: set cfg_done and go to IDLE.
  - Otherwise: idx + 1 and stay in CFG_WR.
- IDLE: go to INIT when start_en = 1.
- INIT: issue 1byte 8'h70. On done, clear the timeout counter and go to WAIT_INT.
- WAIT_INT:
  - Synchronised INTN = 0: go to RD_RES.
  - Counter = TIMEOUT_CYC − 1: pulse timeout_err and go to IDLE.
  - INTN low on the same cycle as the timeout: INTN wins.
- RD_RES: issue rd 8'hB0. On done, latch TDC_RDdata into a holding register.
- RD_STAT: issue rd 8'hB4. On done, go to OUT.
- OUT: load tdc_result from the holding register and tdc_status from the status read; pulse result_valid. Go to INIT if start_en = 1, else IDLE.
- Issue protocol, identical for every command:
  - Drive TDC_CMD, TDC_WRdata and exactly one request line high.
  - Hold them until the cycle TDC_CMDack = 1; drop the request on the next edge.
  - Then wait for TDC_CMDdone. No new request until done has been seen.
- start_en falling mid-sequence does not abort: the current measurement completes.
- idx is 3 bits and never exceeds 6. The timeout counter is 16 bits and saturates.

## Timing
- Reset values: all request lines 0, TDC_CMD 8'h00, TDC_WRdata 0, cfg_done 0, tdc_result 0, tdc_status 0, result_valid 0, timeout_err 0. State = RST_WAIT.
- rst_n low in any state: outputs take reset values on the next edge and RST_WAIT restarts. This applies mid-transfer too; in-flight engine pulses are discarded.
- Request is asserted on the cycle after state entry. The engine acks 1 cycle after it samples the request. A request is therefore high for 2 cycles when the engine is in its idle state.
- Engine transfer times: ≈40 cycles for 1byte and ≈170 cycles for wr/rd from ack to done, plus ≥3 idle cycles between transfers. The engine's own inter-command gap enforces this; the sequencer adds none.
- INTN synchroniser adds 2 cycles of latency.
- result_valid is asserted 1 cycle after the RD_STAT done pulse.

## Test plan
- Power-up: CFG_REG0 = 32'h0012_3456, engine BFM acks after 1 cycle and sends done 170 cycles later.
  - Required: 1byte 8'h50, then wr 8'h80 … 8'h86 with matching data, in order.
  - Required: no requests before cycle RESET_WAIT; cfg_done rises after the 7th done.
- Measurement: start_en = 1, INTN low 500 cycles after the 8'h70 done, BFM read data 32'hCAFE_0001 then 32'hABCD_0000.
  - Required: one result_valid with tdc_result = 32'hCAFE_0001 and tdc_status = 16'hABCD.
- Timeout: INTN held high. Required: timeout_err exactly TIMEOUT_CYC cycles after entering WAIT_INT, no result_valid, then the next 8'h70 if start_en is still 1.
- Delayed ack: BFM delays ack 20 cycles. Required: request and TDC_CMD stay stable for all 20 cycles, drop 1 cycle after ack, and exactly one transfer occurs.
- Reset mid-write: rst_n low for 1 cycle during the 8'h83 write, with a stale done arriving 100 cycles later.
  - Required: stale done ignored; sequence restarts at 8'h50 after RESET_WAIT.
- start_en deasserted during RD_RES. Required: RD_STAT still runs, result_valid pulses once, and the block returns to IDLE.

Source files
------------

// File: rtl/gp22_seq_ctrl.sv
// GP22 TDC command sequencer: power-on reset and configuration, then an endless
// Init / wait-for-INTN / read-result / read-status measurement loop.
module gp22_seq_ctrl #(
  parameter logic [31:0] CFG_REG0    = 32'h0000_0000,
  parameter logic [31:0] CFG_REG1    = 32'h0000_0000,
  parameter logic [31:0] CFG_REG2    = 32'h0000_0000,
  parameter logic [31:0] CFG_REG3    = 32'h0000_0000,
  parameter logic [31:0] CFG_REG4    = 32'h0000_0000,
  parameter logic [31:0] CFG_REG5    = 32'h0000_0000,
  parameter logic [31:0] CFG_REG6    = 32'h0000_0000,
  parameter logic [15:0] RESET_WAIT  = 16'd256,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_en,
  input  logic        tdc_intn,
  output logic        CMD_TDCwr,
  output logic        CMD_TDCrd,
  output logic        CMD_TDC1byte,
  output logic [7:0]  TDC_CMD,
  output logic [31:0] TDC_WRdata,
  input  logic        TDC_CMDack,
  input  logic [31:0] TDC_RDdata,
  input  logic        TDC_CMDdone,
  output logic        cfg_done,
  output logic [31:0] tdc_result,
  output logic [15:0] tdc_status,
  output logic        result_valid,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    ST_RST_WAIT, ST_POR, ST_CFG_WR, ST_IDLE, ST_INIT,
    ST_WAIT_INT, ST_RD_RES, ST_RD_STAT, ST_OUT
  } state_t;

  typedef enum logic [1:0] {PH_ISSUE, PH_ACK, PH_DONE} phase_t;

  localparam logic [2:0] REQ_WR = 3'b100;
  localparam logic [2:0] REQ_RD = 3'b010;
  localparam logic [2:0] REQ_1B = 3'b001;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [2:0]  req_q, req_d;
  logic [7:0]  tdc_cmd_q, tdc_cmd_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        cfg_done_q, cfg_done_d;
  logic [31:0] tdc_result_q, tdc_result_d;
  logic [15:0] tdc_status_q, tdc_status_d;
  logic        result_valid_q, result_valid_d;
  logic        timeout_err_q, timeout_err_d;
  logic        intn_s1_q, intn_s2_q;

  logic        is_cmd_s;
  logic [2:0]  kind_s;
  logic [7:0]  op_s;
  logic [31:0] wdata_s;
  logic        xfer_done_s;

  function automatic logic [31:0] cfg_val(input logic [2:0] idx);
    case (idx)
      3'd0:    cfg_val = CFG_REG0;
      3'd1:    cfg_val = CFG_REG1;
      3'd2:    cfg_val = CFG_REG2;
      3'd3:    cfg_val = CFG_REG3;
      3'd4:    cfg_val = CFG_REG4;
      3'd5:    cfg_val = CFG_REG5;
      3'd6:    cfg_val = CFG_REG6;
      default: cfg_val = 32'h0000_0000;
    endcase
  endfunction

  // Command attached to each command-issuing state
  always_comb begin
    is_cmd_s = 1'b1;
    kind_s   = REQ_1B;
    op_s     = 8'h00;
    wdata_s  = 32'h0000_0000;
    case (state_q)
      ST_POR:     op_s = 8'h50;
      ST_CFG_WR: begin
        kind_s  = REQ_WR;
        op_s    = 8'h80 + {5'd0, idx_q};
        wdata_s = cfg_val(idx_q);
      end
      ST_INIT:    op_s = 8'h70;
      ST_RD_RES: begin
        kind_s = REQ_RD;
        op_s   = 8'hB0;
      end
      ST_RD_STAT: begin
        kind_s = REQ_RD;
        op_s   = 8'hB4;
      end
      default:    is_cmd_s = 1'b0;
    endcase
  end

  assign xfer_done_s = is_cmd_s && (phase_q == PH_DONE) && TDC_CMDdone;

  // Request handshake and next-state logic
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    req_d          = req_q;
    tdc_cmd_d      = tdc_cmd_q;
    wrdata_d       = wrdata_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    hold_d         = hold_q;
    cfg_done_d     = cfg_done_q;
    tdc_result_d   = tdc_result_q;
    tdc_status_d   = tdc_status_q;
    result_valid_d = 1'b0;
    timeout_err_d  = 1'b0;

    if (is_cmd_s) begin
      case (phase_q)
        PH_ISSUE: begin
          req_d     = kind_s;
          tdc_cmd_d = op_s;
          wrdata_d  = wdata_s;
          phase_d   = PH_ACK;
        end
        PH_ACK: begin
          if (TDC_CMDack) begin
            req_d   = 3'b000;
            phase_d = PH_DONE;
          end else begin
            req_d = req_q;
          end
        end
        PH_DONE: phase_d = PH_DONE;
        default: phase_d = PH_ISSUE;
      endcase
    end else begin
      phase_d = PH_ISSUE;
    end

    // Every completed transfer rearms the handshake for the following command
    if (xfer_done_s) begin
      phase_d = PH_ISSUE;
    end else begin
      phase_d = phase_d;
    end

    case (state_q)
      ST_RST_WAIT: begin
        if (cnt_q >= RESET_WAIT - 16'd1) begin
          state_d = ST_POR;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_POR: begin
        if (xfer_done_s) begin
          state_d = ST_CFG_WR;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_POR;
        end
      end
      ST_CFG_WR: begin
        if (xfer_done_s && (idx_q == 3'd6)) begin
          cfg_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (xfer_done_s) begin
          idx_d = idx_q + 3'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      ST_IDLE: begin
        if (start_en) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (xfer_done_s) begin
          cnt_d   = 16'd0;
          state_d = ST_WAIT_INT;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_WAIT_INT: begin
        if (!intn_s2_q) begin
          state_d = ST_RD_RES;
        end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RD_RES: begin
        if (xfer_done_s) begin
          hold_d  = TDC_RDdata;
          state_d = ST_RD_STAT;
        end else begin
          state_d = ST_RD_RES;
        end
      end
      ST_RD_STAT: begin
        // Outputs are loaded here so result_valid follows the done pulse by one cycle
        if (xfer_done_s) begin
          tdc_result_d   = hold_q;
          tdc_status_d   = TDC_RDdata[31:16];
          result_valid_d = 1'b1;
          state_d        = ST_OUT;
        end else begin
          state_d = ST_RD_STAT;
        end
      end
      ST_OUT: begin
        if (start_en) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RST_WAIT;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RST_WAIT;
      phase_q        <= PH_ISSUE;
      req_q          <= 3'b000;
      tdc_cmd_q      <= 8'h00;
      wrdata_q       <= 32'h0000_0000;
      idx_q          <= 3'd0;
      cnt_q          <= 16'd0;
      hold_q         <= 32'h0000_0000;
      cfg_done_q     <= 1'b0;
      tdc_result_q   <= 32'h0000_0000;
      tdc_status_q   <= 16'h0000;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      intn_s1_q      <= 1'b1;
      intn_s2_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      req_q          <= req_d;
      tdc_cmd_q      <= tdc_cmd_d;
      wrdata_q       <= wrdata_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      hold_q         <= hold_d;
      cfg_done_q     <= cfg_done_d;
      tdc_result_q   <= tdc_result_d;
      tdc_status_q   <= tdc_status_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
      intn_s1_q      <= tdc_intn;
      intn_s2_q      <= intn_s1_q;
    end
  end

  assign CMD_TDCwr    = req_q[2];
  assign CMD_TDCrd    = req_q[1];
  assign CMD_TDC1byte = req_q[0];
  assign TDC_CMD      = tdc_cmd_q;
  assign TDC_WRdata   = wrdata_q;
  assign cfg_done     = cfg_done_q;
  assign tdc_result   = tdc_result_q;
  assign tdc_status   = tdc_status_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_gp22_seq_ctrl.sv
// Scoreboard bench for gp22_seq_ctrl: an engine BFM answers requests, a monitor
// pops hand-computed expected commands/results and compares them.
module tb_gp22_seq_ctrl;

  localparam logic [15:0] RW = 16'd256;
  localparam logic [15:0] TO = 16'd4000;
  localparam logic [2:0]  R_WR = 3'b100;
  localparam logic [2:0]  R_RD = 3'b010;
  localparam logic [2:0]  R_1B = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n, start_en, tdc_intn;
  logic        CMD_TDCwr, CMD_TDCrd, CMD_TDC1byte;
  logic [7:0]  TDC_CMD;
  logic [31:0] TDC_WRdata;
  logic        TDC_CMDack, TDC_CMDdone;
  logic [31:0] TDC_RDdata;
  logic        cfg_done, result_valid, timeout_err;
  logic [31:0] tdc_result;
  logic [15:0] tdc_status;

  logic [31:0] cfg_tab [7] = '{32'h0012_3456, 32'h1111_0001, 32'h2222_0002,
                               32'hDEAD_BEEF, 32'h4444_0004, 32'h5555_0005, 32'h6666_0006};

  typedef struct {
    int          kind;   // 0 command, 1 result, 2 timeout
    logic [2:0]  req;
    logic [7:0]  cmd;
    logic [31:0] data;
    logic [15:0] stat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ack_dly = 1;
  int          ack_cnt [256];
  int          done_cnt [256];
  logic [7:0]  last_done_cmd = 8'h00;
  int          last_done_cyc = 0;

  gp22_seq_ctrl #(
    .CFG_REG0(32'h0012_3456), .CFG_REG1(32'h1111_0001), .CFG_REG2(32'h2222_0002),
    .CFG_REG3(32'hDEAD_BEEF), .CFG_REG4(32'h4444_0004), .CFG_REG5(32'h5555_0005),
    .CFG_REG6(32'h6666_0006), .RESET_WAIT(RW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_en(start_en), .tdc_intn(tdc_intn),
    .CMD_TDCwr(CMD_TDCwr), .CMD_TDCrd(CMD_TDCrd), .CMD_TDC1byte(CMD_TDC1byte),
    .TDC_CMD(TDC_CMD), .TDC_WRdata(TDC_WRdata), .TDC_CMDack(TDC_CMDack),
    .TDC_RDdata(TDC_RDdata), .TDC_CMDdone(TDC_CMDdone), .cfg_done(cfg_done),
    .tdc_result(tdc_result), .tdc_status(tdc_status), .result_valid(result_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_tx(input logic [2:0] r, input logic [7:0] c, input logic [31:0] d);
    exp_t e;
    e.kind = 0; e.req = r; e.cmd = c; e.data = d; e.stat = 16'h0000;
    exp_q.push_back(e);
  endtask

  task automatic push_other(input int k, input logic [31:0] d, input logic [15:0] s);
    exp_t e;
    e.kind = k; e.req = 3'b000; e.cmd = 8'h00; e.data = d; e.stat = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input logic [7:0] c, input int target, input int budget);
    int i = 0;
    while (ack_cnt[c] < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("wait_ack_%0h", c), 64'(ack_cnt[c] >= target), 64'd1);
  endtask

  task automatic wait_done(input logic [7:0] c, input int target, input int budget);
    int i = 0;
    while (done_cnt[c] < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("wait_done_%0h", c), 64'(done_cnt[c] >= target), 64'd1);
  endtask

  // Engine BFM: ack after ack_dly cycles, done 40 (1byte) or 170 (wr/rd) cycles later
  initial begin
    logic [2:0] k;
    logic [7:0] c;
    forever begin
      @(negedge clk);
      if (rst_n && {CMD_TDCwr, CMD_TDCrd, CMD_TDC1byte} != 3'b000) begin
        k = {CMD_TDCwr, CMD_TDCrd, CMD_TDC1byte};
        c = TDC_CMD;
        for (int i = 0; i < ack_dly; i++) begin
          @(negedge clk);
          check("req_hold", {53'd0, CMD_TDCwr, CMD_TDCrd, CMD_TDC1byte, TDC_CMD}, {53'd0, k, c});
        end
        TDC_CMDack = 1'b1;
        ack_cnt[c]++;
        @(negedge clk);
        TDC_CMDack = 1'b0;
        check("req_drop", {61'd0, CMD_TDCwr, CMD_TDCrd, CMD_TDC1byte}, 64'd0);
        repeat ((k == R_1B) ? 39 : 169) @(negedge clk);
        if (k == R_RD) TDC_RDdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0000_0000;
        TDC_CMDdone = 1'b1;
        done_cnt[c]++;
        last_done_cmd = c;
        last_done_cyc = cyc;
        @(negedge clk);
        TDC_CMDdone = 1'b0;
      end
    end
  end

  // Monitor: compare each new request, result and timeout against the scoreboard
  initial begin
    logic [2:0] req, req_prev;
    logic       cfg_prev;
    logic       first_req;
    int         rel_cyc;
    exp_t       e;
    req_prev = 3'b000; cfg_prev = 1'b0; first_req = 1'b1; rel_cyc = 0;
    forever begin
      @(negedge clk);
      req = {CMD_TDCwr, CMD_TDCrd, CMD_TDC1byte};
      if (!rst_n) begin
        first_req = 1'b1;
        rel_cyc   = cyc;
      end else begin
        if (req != 3'b000 && req_prev == 3'b000) begin
          if (first_req) check("reset_wait", 64'((cyc - rel_cyc) >= int'(RW)), 64'd1);
          first_req = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_req", {56'd0, TDC_CMD}, 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("req_kind", 64'(e.kind), 64'd0);
            check("req_line", {61'd0, req}, {61'd0, e.req});
            check("req_cmd", {56'd0, TDC_CMD}, {56'd0, e.cmd});
            if (e.req == R_WR) check("req_wdata", {32'd0, TDC_WRdata}, {32'd0, e.data});
          end
        end
        if (result_valid) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '{kind: 9, req: 3'b0, cmd: 8'h0, data: 32'h0, stat: 16'h0};
          check("res_kind", 64'(e.kind), 64'd1);
          check("res_result", {32'd0, tdc_result}, {32'd0, e.data});
          check("res_status", {48'd0, tdc_status}, {48'd0, e.stat});
          check("res_latency", 64'(cyc), 64'(last_done_cyc + 1));
        end
        if (timeout_err) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '{kind: 9, req: 3'b0, cmd: 8'h0, data: 32'h0, stat: 16'h0};
          check("tmo_kind", 64'(e.kind), 64'd2);
          check("tmo_time", 64'(cyc), 64'(last_done_cyc + 1 + int'(TO)));
        end
        if (cfg_done && !cfg_prev) begin
          check("cfg_done_cmd", {56'd0, last_done_cmd}, 64'h86);
          check("cfg_done_time", 64'(cyc), 64'(last_done_cyc + 1));
        end
      end
      req_prev = req;
      cfg_prev = cfg_done;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_en = 1'b0; tdc_intn = 1'b1;
    TDC_CMDack = 1'b0; TDC_CMDdone = 1'b0; TDC_RDdata = 32'h0000_0000;
    repeat (3) @(negedge clk);
    check("rst_req", {61'd0, CMD_TDCwr, CMD_TDCrd, CMD_TDC1byte}, 64'd0);
    check("rst_cmd", {56'd0, TDC_CMD}, 64'd0);
    check("rst_wrdata", {32'd0, TDC_WRdata}, 64'd0);
    check("rst_flags", {60'd0, cfg_done, result_valid, timeout_err, 1'b0}, 64'd0);
    check("rst_result", {16'd0, tdc_result, tdc_status}, 64'd0);

    // Power-up, interrupted by a one-cycle reset during the 8'h83 write
    push_tx(R_1B, 8'h50, 32'h0);
    for (int i = 0; i < 4; i++) push_tx(R_WR, 8'h80 + 8'(i), cfg_tab[i]);
    rst_n = 1'b1;
    wait_ack(8'h83, 1, 3000);
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_req", {61'd0, CMD_TDCwr, CMD_TDCrd, CMD_TDC1byte}, 64'd0);
    check("midrst_cmd", {56'd0, TDC_CMD}, 64'd0);
    push_tx(R_1B, 8'h50, 32'h0);
    for (int i = 0; i < 7; i++) push_tx(R_WR, 8'h80 + 8'(i), cfg_tab[i]);
    wait_done(8'h86, 1, 3000);
    @(negedge clk);
    check("cfg_done_level", {63'd0, cfg_done}, 64'd1);

    // Measurement with INTN 500 cycles after the Init done
    push_tx(R_1B, 8'h70, 32'h0);
    push_tx(R_RD, 8'hB0, 32'h0);
    push_tx(R_RD, 8'hB4, 32'h0);
    push_other(1, 32'hCAFE_0001, 16'hABCD);
    rd_q.push_back(32'hCAFE_0001);
    rd_q.push_back(32'hABCD_0000);
    // Then a timeout, a delayed-ack Init, and a measurement stopped by start_en
    push_tx(R_1B, 8'h70, 32'h0);
    push_other(2, 32'h0, 16'h0);
    push_tx(R_1B, 8'h70, 32'h0);
    push_tx(R_RD, 8'hB0, 32'h0);
    push_tx(R_RD, 8'hB4, 32'h0);
    push_other(1, 32'h1234_5678, 16'h8765);
    rd_q.push_back(32'h1234_5678);
    rd_q.push_back(32'h8765_4321);
    start_en = 1'b1;
    wait_done(8'h70, 1, 500);
    repeat (500) @(negedge clk);
    tdc_intn = 1'b0;
    wait_ack(8'hB0, 1, 100);
    tdc_intn = 1'b1;

    wait_done(8'h70, 2, 1000);
    ack_dly = 20;
    wait_ack(8'h70, 3, 5000);
    ack_dly = 1;
    check("tmo_seen_no_extra_res", 64'(done_cnt[8'hB4]), 64'd1);
    wait_done(8'h70, 3, 200);
    repeat (50) @(negedge clk);
    tdc_intn = 1'b0;
    wait_ack(8'hB0, 2, 100);
    start_en = 1'b0;
    tdc_intn = 1'b1;
    wait_done(8'hB4, 2, 1000);
    repeat (400) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("idle_no_init", 64'(ack_cnt[8'h70]), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
